// File: rtl/rom_loader.sv
// rom_loader: copies a ROM image out of an SPI flash into SRAM after reset.
// Issues one continuous READ (0x03) command, then for every byte clocks it in
// over SPI mode 0 and performs a setup / 2-cycle write pulse / hold sequence
// on the SRAM port. The CPU is held off the bus (active=1) until the copy ends.
module rom_loader #(
    parameter logic [23:0] FLASH_OFFSET = 24'h100000,
    parameter logic [16:0] LENGTH       = 17'h1C000,
    parameter int unsigned SCK_DIV      = 2
) (
    input  logic        clk28,
    input  logic        rst,
    input  logic        spi_miso,
    output logic        spi_sck,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    output logic [16:0] rom2ram_ram_address,
    output logic        rom2ram_ram_wren,
    output logic [7:0]  rom2ram_dataout,
    output logic        active,
    output logic        done
);

    localparam int unsigned     DIV_W     = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
    localparam logic [16:0]     LAST_ADDR = LENGTH - 17'd1;
    localparam logic [31:0]     READ_CMD  = {8'h03, FLASH_OFFSET};

    typedef enum logic [2:0] {
        StWait,
        StCmd,
        StData,
        StWsetup,
        StWpulse,
        StWhold,
        StDone
    } state_t;

    state_t           state;
    logic [2:0]       wait_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       bit_cnt;
    logic             pulse_cnt;
    logic [31:0]      cmd_sr;
    logic [7:0]       rx_sr;
    logic             half_done;

    // End of the current SCK half-period.
    assign half_done = (div_cnt == DIV_LAST);

    // Sequencer: SPI command/data shifting and SRAM write timing, all outputs registered.
    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            state               <= StWait;
            wait_cnt            <= '0;
            div_cnt             <= '0;
            bit_cnt             <= '0;
            pulse_cnt           <= 1'b0;
            cmd_sr              <= '0;
            rx_sr               <= '0;
            spi_sck             <= 1'b0;
            spi_cs_n            <= 1'b1;
            spi_mosi            <= 1'b0;
            rom2ram_ram_address <= '0;
            rom2ram_ram_wren    <= 1'b0;
            rom2ram_dataout     <= '0;
            active              <= 1'b1;
            done                <= 1'b0;
        end else begin
            unique case (state)
                StWait: begin
                    wait_cnt <= wait_cnt + 3'd1;
                    if (wait_cnt == 3'd7) begin
                        if (LENGTH == 17'd0) begin
                            // Nothing to copy: never touch the flash.
                            state  <= StDone;
                            active <= 1'b0;
                            done   <= 1'b1;
                        end else begin
                            // First command bit is presented with SCK low.
                            state    <= StCmd;
                            spi_cs_n <= 1'b0;
                            spi_mosi <= READ_CMD[31];
                            cmd_sr   <= {READ_CMD[30:0], 1'b0};
                            div_cnt  <= '0;
                            bit_cnt  <= '0;
                        end
                    end
                end

                StCmd: begin
                    if (half_done) begin
                        div_cnt <= '0;
                        if (!spi_sck) begin
                            spi_sck <= 1'b1;
                        end else begin
                            // Falling edge: MOSI only changes here, while SCK goes low.
                            spi_sck <= 1'b0;
                            if (bit_cnt == 5'd31) begin
                                state    <= StData;
                                spi_mosi <= 1'b0;
                                bit_cnt  <= '0;
                            end else begin
                                bit_cnt  <= bit_cnt + 5'd1;
                                spi_mosi <= cmd_sr[31];
                                cmd_sr   <= {cmd_sr[30:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                StData: begin
                    if (half_done) begin
                        div_cnt <= '0;
                        if (!spi_sck) begin
                            // Rising edge: capture the bit the flash set on the last falling edge.
                            spi_sck <= 1'b1;
                            rx_sr   <= {rx_sr[6:0], spi_miso};
                        end else begin
                            spi_sck <= 1'b0;
                            if (bit_cnt == 5'd7) begin
                                state           <= StWsetup;
                                bit_cnt         <= '0;
                                rom2ram_dataout <= rx_sr;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                StWsetup: begin
                    state            <= StWpulse;
                    rom2ram_ram_wren <= 1'b1;
                    pulse_cnt        <= 1'b0;
                end

                StWpulse: begin
                    if (pulse_cnt) begin
                        state            <= StWhold;
                        rom2ram_ram_wren <= 1'b0;
                    end else begin
                        pulse_cnt <= 1'b1;
                    end
                end

                StWhold: begin
                    if (rom2ram_ram_address == LAST_ADDR) begin
                        state    <= StDone;
                        spi_cs_n <= 1'b1;
                        active   <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        // Address advances only after the hold cycle so it stays stable
                        // one cycle past the write pulse.
                        rom2ram_ram_address <= rom2ram_ram_address + 17'd1;
                        state               <= StData;
                        div_cnt             <= '0;
                    end
                end

                StDone: begin
                    state <= StDone;
                end

                default: begin
                    state <= StWait;
                end
            endcase
        end
    end

endmodule
